// File: rtl/ether_rx_pkg.sv
// Shared definitions for the receive-side Ethernet/IP/UDP parsers.
package ether_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ_HDR = 3'd1,
    ST_HDR_OUT  = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_DROP     = 3'd4
  } rx_state_t;

  localparam int         UDP_HDR_BYTES = 8;
  localparam logic [7:0] IP_PROTO_UDP  = 8'd17;

endpackage

// File: rtl/udp_rx_parser.sv
// UDP receive parser: keeps UDP datagrams from the IP receive stream, parses
// the 8-byte UDP header, optionally filters on destination port, and forwards
// the payload trimmed to the UDP length (strips Ethernet padding).
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for an IP header
// ST_READ_HDR | shifting in the 8 UDP header bytes
// ST_HDR_OUT  | presenting the parsed UDP header downstream
// ST_PAYLOAD  | passing payload bytes through until UDP length is reached
// ST_DROP     | discarding the rest of the IP payload up to tlast
module udp_rx_parser
  import ether_rx_pkg::*;
#(
  parameter logic [7:0] UDP_PROTOCOL   = IP_PROTO_UDP,
  parameter int         DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      s_ip_hdr_valid,
  output logic                      s_ip_hdr_ready,
  input  logic [7:0]                s_ip_protocol,
  input  logic [31:0]               s_ip_source_ip,
  input  logic [31:0]               s_ip_dest_ip,
  input  logic [7:0]                s_ip_payload_axis_tdata,
  input  logic                      s_ip_payload_axis_tvalid,
  output logic                      s_ip_payload_axis_tready,
  input  logic                      s_ip_payload_axis_tlast,
  input  logic                      s_ip_payload_axis_tuser,

  output logic                      m_udp_hdr_valid,
  input  logic                      m_udp_hdr_ready,
  output logic [31:0]               m_udp_source_ip,
  output logic [31:0]               m_udp_dest_ip,
  output logic [15:0]               m_udp_source_port,
  output logic [15:0]               m_udp_dest_port,
  output logic [15:0]               m_udp_length,
  output logic [15:0]               m_udp_checksum,
  output logic [7:0]                m_udp_payload_axis_tdata,
  output logic                      m_udp_payload_axis_tvalid,
  input  logic                      m_udp_payload_axis_tready,
  output logic                      m_udp_payload_axis_tlast,
  output logic                      m_udp_payload_axis_tuser,

  input  logic [15:0]               local_port,
  input  logic                      port_filter_en,

  output logic                      error_header_early_termination,
  output logic                      error_payload_early_termination,
  output logic [DROP_CNT_WIDTH-1:0] dropped_count
);

  localparam logic [15:0] HDR_LEN = 16'(UDP_HDR_BYTES);

  rx_state_t   state, state_next;
  logic        armed;
  logic [2:0]  byte_cnt;
  logic [63:0] hdr_shift;
  logic [15:0] remaining;
  logic [31:0] src_ip_q, dst_ip_q;

  logic        hdr_hs, pay_hs, hdr_out_hs;
  logic        drop_inc, hdr_err, pay_err;

  // After seven header bytes the dst port and length sit at fixed offsets
  // of the shift register, so byte 7 can be judged in the same cycle.
  logic [15:0] dst_at7, len_at7;
  assign dst_at7 = hdr_shift[39:24];
  assign len_at7 = hdr_shift[23:8];

  assign hdr_hs     = s_ip_hdr_valid && s_ip_hdr_ready;
  assign pay_hs     = (state == ST_PAYLOAD) && s_ip_payload_axis_tvalid && m_udp_payload_axis_tready;
  assign hdr_out_hs = (state == ST_HDR_OUT) && m_udp_hdr_ready;

  assign m_udp_source_ip   = src_ip_q;
  assign m_udp_dest_ip     = dst_ip_q;
  assign m_udp_source_port = hdr_shift[63:48];
  assign m_udp_dest_port   = hdr_shift[47:32];
  assign m_udp_length      = hdr_shift[31:16];
  assign m_udp_checksum    = hdr_shift[15:0];

  // Next-state, handshake and payload pass-through decode.
  always_comb begin
    state_next                = state;
    s_ip_hdr_ready            = 1'b0;
    s_ip_payload_axis_tready  = 1'b0;
    m_udp_hdr_valid           = 1'b0;
    m_udp_payload_axis_tdata  = 8'd0;
    m_udp_payload_axis_tvalid = 1'b0;
    m_udp_payload_axis_tlast  = 1'b0;
    m_udp_payload_axis_tuser  = 1'b0;
    drop_inc                  = 1'b0;
    hdr_err                   = 1'b0;
    pay_err                   = 1'b0;
    case (state)
      ST_IDLE: begin
        s_ip_hdr_ready = armed;
        if (armed && s_ip_hdr_valid) begin
          if (s_ip_protocol == UDP_PROTOCOL) begin
            state_next = ST_READ_HDR;
          end else begin
            state_next = ST_DROP;
            drop_inc   = 1'b1;
          end
        end
      end
      ST_READ_HDR: begin
        s_ip_payload_axis_tready = 1'b1;
        if (s_ip_payload_axis_tvalid) begin
          if (byte_cnt != 3'd7) begin
            if (s_ip_payload_axis_tlast) begin
              hdr_err    = 1'b1;
              drop_inc   = 1'b1;
              state_next = ST_IDLE;
            end
          end else if ((len_at7 <= HDR_LEN) ||
                       (port_filter_en && (dst_at7 != local_port))) begin
            drop_inc   = 1'b1;
            state_next = s_ip_payload_axis_tlast ? ST_IDLE : ST_DROP;
          end else if (s_ip_payload_axis_tlast) begin
            hdr_err    = 1'b1;
            drop_inc   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_HDR_OUT;
          end
        end
      end
      ST_HDR_OUT: begin
        m_udp_hdr_valid = 1'b1;
        if (m_udp_hdr_ready) state_next = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        s_ip_payload_axis_tready  = m_udp_payload_axis_tready;
        m_udp_payload_axis_tvalid = s_ip_payload_axis_tvalid;
        m_udp_payload_axis_tdata  = s_ip_payload_axis_tdata;
        if (remaining == 16'd1) begin
          m_udp_payload_axis_tlast = 1'b1;
          m_udp_payload_axis_tuser = s_ip_payload_axis_tuser;
        end else if (s_ip_payload_axis_tlast) begin
          m_udp_payload_axis_tlast = 1'b1;
          m_udp_payload_axis_tuser = 1'b1;
        end else begin
          m_udp_payload_axis_tuser = s_ip_payload_axis_tuser;
        end
        if (pay_hs) begin
          if (remaining == 16'd1) begin
            state_next = s_ip_payload_axis_tlast ? ST_IDLE : ST_DROP;
          end else if (s_ip_payload_axis_tlast) begin
            pay_err    = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        s_ip_payload_axis_tready = 1'b1;
        if (s_ip_payload_axis_tvalid && s_ip_payload_axis_tlast) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; armed holds header-ready low until the first edge out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
    end
  end

  // Header capture: IP addresses on the IP header handshake, UDP header bytes by shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ip_q  <= 32'd0;
      dst_ip_q  <= 32'd0;
      byte_cnt  <= 3'd0;
      hdr_shift <= 64'd0;
    end else begin
      if (hdr_hs) begin
        src_ip_q <= s_ip_source_ip;
        dst_ip_q <= s_ip_dest_ip;
        byte_cnt <= 3'd0;
      end else if ((state == ST_READ_HDR) && s_ip_payload_axis_tvalid) begin
        byte_cnt  <= byte_cnt + 3'd1;
        hdr_shift <= {hdr_shift[55:0], s_ip_payload_axis_tdata};
      end
    end
  end

  // Payload byte down-counter, loaded with the UDP payload length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= 16'd0;
    end else if (hdr_out_hs) begin
      remaining <= m_udp_length - HDR_LEN;
    end else if (pay_hs) begin
      remaining <= remaining - 16'd1;
    end
  end

  // Registered error pulses and wrapping dropped-datagram counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_header_early_termination  <= 1'b0;
      error_payload_early_termination <= 1'b0;
      dropped_count                   <= '0;
    end else begin
      error_header_early_termination  <= hdr_err;
      error_payload_early_termination <= pay_err;
      if (drop_inc) dropped_count <= dropped_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed bench for udp_rx_parser: table of datagrams plus a hand-written
// backpressure / mid-payload reset sequence.
module tb_udp_rx_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_ip_hdr_valid = 1'b0;
  logic        s_ip_hdr_ready;
  logic [7:0]  s_ip_protocol = 8'd0;
  logic [31:0] s_ip_source_ip = 32'd0;
  logic [31:0] s_ip_dest_ip = 32'd0;
  logic [7:0]  s_tdata = 8'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic        m_udp_hdr_valid;
  logic        m_udp_hdr_ready = 1'b1;
  logic [31:0] m_udp_source_ip, m_udp_dest_ip;
  logic [15:0] m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast, m_tuser;
  logic [15:0] local_port = 16'd7400;
  logic        port_filter_en = 1'b1;
  logic        err_hdr, err_pay;
  logic [15:0] dropped_count;

  udp_rx_parser dut (
    .clk                             (clk),
    .rst                             (rst),
    .s_ip_hdr_valid                  (s_ip_hdr_valid),
    .s_ip_hdr_ready                  (s_ip_hdr_ready),
    .s_ip_protocol                   (s_ip_protocol),
    .s_ip_source_ip                  (s_ip_source_ip),
    .s_ip_dest_ip                    (s_ip_dest_ip),
    .s_ip_payload_axis_tdata         (s_tdata),
    .s_ip_payload_axis_tvalid        (s_tvalid),
    .s_ip_payload_axis_tready        (s_tready),
    .s_ip_payload_axis_tlast         (s_tlast),
    .s_ip_payload_axis_tuser         (s_tuser),
    .m_udp_hdr_valid                 (m_udp_hdr_valid),
    .m_udp_hdr_ready                 (m_udp_hdr_ready),
    .m_udp_source_ip                 (m_udp_source_ip),
    .m_udp_dest_ip                   (m_udp_dest_ip),
    .m_udp_source_port               (m_udp_source_port),
    .m_udp_dest_port                 (m_udp_dest_port),
    .m_udp_length                    (m_udp_length),
    .m_udp_checksum                  (m_udp_checksum),
    .m_udp_payload_axis_tdata        (m_tdata),
    .m_udp_payload_axis_tvalid       (m_tvalid),
    .m_udp_payload_axis_tready       (m_tready),
    .m_udp_payload_axis_tlast        (m_tlast),
    .m_udp_payload_axis_tuser        (m_tuser),
    .local_port                      (local_port),
    .port_filter_en                  (port_filter_en),
    .error_header_early_termination  (err_hdr),
    .error_payload_early_termination (err_pay),
    .dropped_count                   (dropped_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Monitor state, sampled on the falling edge.
  int          hdr_cnt, out_n, tlast_cnt, tlast_idx, herr_cnt, perr_cnt;
  logic        last_tuser;
  logic [7:0]  out_data [0:63];
  logic [15:0] cap_sport, cap_dport, cap_len, cap_cksum;
  logic [31:0] cap_sip, cap_dip;

  logic [7:0]  fb [0:63];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    hdr_cnt = 0; out_n = 0; tlast_cnt = 0; tlast_idx = -1;
    herr_cnt = 0; perr_cnt = 0; last_tuser = 1'b0;
  endtask

  // Observe DUT outputs on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_udp_hdr_valid && m_udp_hdr_ready) begin
        hdr_cnt++;
        cap_sport = m_udp_source_port; cap_dport = m_udp_dest_port;
        cap_len = m_udp_length; cap_cksum = m_udp_checksum;
        cap_sip = m_udp_source_ip; cap_dip = m_udp_dest_ip;
      end
      if (m_tvalid && m_tready) begin
        if (out_n < 64) out_data[out_n] = m_tdata;
        if (m_tlast) begin
          tlast_cnt++;
          tlast_idx = out_n;
          last_tuser = m_tuser;
        end
        out_n++;
      end
      if (err_hdr) herr_cnt++;
      if (err_pay) perr_cnt++;
    end
  end

  task automatic build_frame(input logic [15:0] dport, input logic [15:0] ulen);
    fb[0] = 8'h12; fb[1] = 8'h34;
    fb[2] = dport[15:8]; fb[3] = dport[7:0];
    fb[4] = ulen[15:8];  fb[5] = ulen[7:0];
    fb[6] = 8'hBE; fb[7] = 8'hEF;
    for (int i = 8; i < 64; i++) fb[i] = 8'hA1 + 8'(i - 8);
  endtask

  task automatic send_ip_hdr(input logic [7:0] proto);
    bit got = 0;
    @(posedge clk); #1;
    s_ip_hdr_valid = 1'b1; s_ip_protocol = proto;
    s_ip_source_ip = 32'hC0A8_0001; s_ip_dest_ip = 32'hC0A8_0002;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (s_ip_hdr_ready) begin got = 1; break; end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL ip_hdr_timeout: got no s_ip_hdr_ready, expected one within 100 cycles");
    end
    @(posedge clk); #1;
    s_ip_hdr_valid = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] d, input logic last, input logic user);
    bit got = 0;
    s_tdata = d; s_tvalid = 1'b1; s_tlast = last; s_tuser = user;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (s_tready) begin got = 1; break; end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL byte_timeout: got no s_tready, expected one within 100 cycles");
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [7:0]  proto;
    logic [15:0] dport;
    logic [15:0] ulen;
    int          nbytes;
    logic        filt;
    logic        tuser_in;
    int          exp_hdr;
    int          exp_out;
    logic        exp_tuser;
    int          exp_drop;
    int          exp_herr;
    int          exp_perr;
  } vec_t;

  vec_t vecs [0:11];

  initial begin
    logic [15:0] drop_before;
    bit          stable;

    //            name        proto  dport   ulen nby filt tu  hdr out tu drop herr perr
    vecs[0]  = '{"basic",     8'd17, 16'd7400, 16'd12, 12, 1'b1, 1'b0, 1, 4, 1'b0, 0, 0, 0};
    vecs[1]  = '{"tcp_drop",  8'd6,  16'd7400, 16'd12, 30, 1'b1, 1'b0, 0, 0, 1'b0, 1, 0, 0};
    vecs[2]  = '{"padding",   8'd17, 16'd7400, 16'd10, 18, 1'b1, 1'b0, 1, 2, 1'b0, 0, 0, 0};
    vecs[3]  = '{"after_pad", 8'd17, 16'd7400, 16'd12, 12, 1'b1, 1'b0, 1, 4, 1'b0, 0, 0, 0};
    vecs[4]  = '{"filt_drop", 8'd17, 16'd7401, 16'd12, 12, 1'b1, 1'b0, 0, 0, 1'b0, 1, 0, 0};
    vecs[5]  = '{"filt_off",  8'd17, 16'd7401, 16'd12, 12, 1'b0, 1'b0, 1, 4, 1'b0, 0, 0, 0};
    vecs[6]  = '{"hdr_early", 8'd17, 16'd7400, 16'd12, 6,  1'b1, 1'b0, 0, 0, 1'b0, 1, 1, 0};
    vecs[7]  = '{"pay_early", 8'd17, 16'd7400, 16'd20, 12, 1'b1, 1'b0, 1, 4, 1'b1, 0, 0, 1};
    vecs[8]  = '{"len8_last", 8'd17, 16'd7400, 16'd8,  8,  1'b1, 1'b0, 0, 0, 1'b0, 1, 0, 0};
    vecs[9]  = '{"len8_drop", 8'd17, 16'd7400, 16'd8,  12, 1'b1, 1'b0, 0, 0, 1'b0, 1, 0, 0};
    vecs[10] = '{"hdr7_last", 8'd17, 16'd7400, 16'd12, 8,  1'b1, 1'b0, 0, 0, 1'b0, 1, 1, 0};
    vecs[11] = '{"tuser_err", 8'd17, 16'd7400, 16'd12, 12, 1'b1, 1'b1, 1, 4, 1'b1, 0, 0, 0};

    clear_mon();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_hdr_ready", 64'(s_ip_hdr_ready), 64'd0);
    check("rst_hdr_valid", 64'(m_udp_hdr_valid), 64'd0);
    check("rst_s_tready",  64'(s_tready), 64'd0);
    check("rst_m_tvalid",  64'(m_tvalid), 64'd0);
    check("rst_dropped",   64'(dropped_count), 64'd0);
    check("rst_errs",      64'({err_hdr, err_pay}), 64'd0);
    check("rst_fields",    64'({m_udp_source_port, m_udp_length, m_udp_source_ip[15:0]}), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready_low", 64'(s_ip_hdr_ready), 64'd0);
    @(negedge clk);
    check("rst_release_ready_high", 64'(s_ip_hdr_ready), 64'd1);

    // Table-driven datagrams
    for (int v = 0; v < 12; v++) begin
      @(posedge clk); #1;
      clear_mon();
      port_filter_en = vecs[v].filt;
      drop_before = dropped_count;
      build_frame(vecs[v].dport, vecs[v].ulen);
      send_ip_hdr(vecs[v].proto);
      for (int i = 0; i < vecs[v].nbytes; i++)
        put_byte(fb[i], i == vecs[v].nbytes - 1, vecs[v].tuser_in && (i == vecs[v].nbytes - 1));
      repeat (4) @(negedge clk);

      check({vecs[v].name, ".hdr_cnt"}, 64'(hdr_cnt), 64'(vecs[v].exp_hdr));
      check({vecs[v].name, ".out_n"}, 64'(out_n), 64'(vecs[v].exp_out));
      check({vecs[v].name, ".dropped"}, 64'(16'(dropped_count - drop_before)), 64'(vecs[v].exp_drop));
      check({vecs[v].name, ".hdr_err"}, 64'(herr_cnt), 64'(vecs[v].exp_herr));
      check({vecs[v].name, ".pay_err"}, 64'(perr_cnt), 64'(vecs[v].exp_perr));
      check({vecs[v].name, ".tlast_cnt"}, 64'(tlast_cnt), 64'(vecs[v].exp_out > 0 ? 1 : 0));
      if (vecs[v].exp_out > 0) begin
        stable = 1;
        for (int i = 0; i < vecs[v].exp_out && i < 64; i++)
          if (out_data[i] !== 8'hA1 + 8'(i)) stable = 0;
        check({vecs[v].name, ".data"}, 64'(stable), 64'd1);
        check({vecs[v].name, ".tlast_idx"}, 64'(tlast_idx), 64'(vecs[v].exp_out - 1));
        check({vecs[v].name, ".tuser"}, 64'(last_tuser), 64'(vecs[v].exp_tuser));
      end
      if (vecs[v].exp_hdr > 0) begin
        check({vecs[v].name, ".sport"}, 64'(cap_sport), 64'h1234);
        check({vecs[v].name, ".dport"}, 64'(cap_dport), 64'(vecs[v].dport));
        check({vecs[v].name, ".len"}, 64'(cap_len), 64'(vecs[v].ulen));
        check({vecs[v].name, ".cksum"}, 64'(cap_cksum), 64'hBEEF);
        check({vecs[v].name, ".ips"}, {cap_sip, cap_dip}, 64'hC0A8_0001_C0A8_0002);
      end
    end

    // Header backpressure for 10 cycles, then reset mid-payload
    @(posedge clk); #1;
    clear_mon();
    port_filter_en = 1'b1;
    m_udp_hdr_ready = 1'b0;
    build_frame(16'd7400, 16'd12);
    send_ip_hdr(8'd17);
    for (int i = 0; i < 8; i++) put_byte(fb[i], 1'b0, 1'b0);
    stable = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!(m_udp_hdr_valid && m_udp_source_port == 16'h1234 && m_udp_dest_port == 16'd7400 &&
            m_udp_length == 16'd12 && m_udp_checksum == 16'hBEEF && !s_tready))
        stable = 0;
    end
    check("bp.hdr_stable", 64'(stable), 64'd1);
    m_udp_hdr_ready = 1'b1;
    @(posedge clk); #1;
    put_byte(fb[8], 1'b0, 1'b0);
    check("bp.first_byte", 64'({out_n[7:0], out_data[0]}), 64'h01A1);
    s_tdata = fb[9]; s_tvalid = 1'b1;
    @(negedge clk);
    check("bp.in_payload", 64'({m_tvalid, m_tdata}), 64'h1A2);
    rst = 1'b1;
    #1;
    check("bp.rst_outputs", 64'({m_tvalid, s_tready, s_ip_hdr_ready, m_udp_hdr_valid, err_hdr, err_pay}), 64'd0);
    check("bp.rst_dropped", 64'(dropped_count), 64'd0);
    check("bp.rst_fields", {m_udp_source_ip, m_udp_length, m_udp_dest_port}, 64'd0);
    s_tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("bp.ready_low_after_rst", 64'(s_ip_hdr_ready), 64'd0);
    @(negedge clk);
    check("bp.ready_high_after_rst", 64'(s_ip_hdr_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
